// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: state encoding and default sizes shared by the accumulator files.
package product_accumulator_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam int PRODUCT_W = 16;
  localparam int ACC_W_DEFAULT = 24;
  localparam int N_DEFAULT = 8;
endpackage

// File: rtl/acc_add_sat.sv
// acc_add_sat: ACC_W-bit accumulate add with carry-out; wraps, or clamps when
// PRODUCT_ACCUMULATOR_SATURATE_EN is defined.
module acc_add_sat import product_accumulator_pkg::*; #(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic [ACC_W-1:0]     i_acc,
  input  logic [PRODUCT_W-1:0] i_product,
  output logic [ACC_W-1:0]     o_sum,
  output logic                 o_carry
);
  logic [ACC_W:0] w_full;
  assign w_full = {1'b0, i_acc} + {{(ACC_W+1-PRODUCT_W){1'b0}}, i_product};
  assign o_carry = w_full[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  assign o_sum = o_carry ? '1 : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums N unsigned products, holds the result until taken.
// PRODUCT_ACCUMULATOR_SATURATE_EN selects clamping instead of wrapping on overflow.
module product_accumulator import product_accumulator_pkg::*; #(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRODUCT_W-1:0] product,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 overflow
);
  localparam int CW = $clog2(N+1);
  state_t r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_sum;
  logic [CW-1:0] r_count;
  logic r_ovf, w_carry, w_accept, w_last, w_restart;
  acc_add_sat #(.ACC_W(ACC_W)) u_add (
    .i_acc(r_acc), .i_product(product), .o_sum(w_sum), .o_carry(w_carry)
  );
  assign in_ready  = (r_state == ACCUM) && !clear;
  assign out_valid = r_state == HOLD;
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = r_count == CW'(N-1);
  // clear and handoff both start a fresh accumulation from zero
  assign w_restart = clear || (out_valid && out_ready);
  always_comb begin
    w_state_nxt = w_restart ? ACCUM : (w_accept && w_last) ? HOLD : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ACCUM;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst || w_restart) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_sum;
      r_count <= r_count + 1'b1;
      r_ovf   <= r_ovf | w_carry;
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and randomized checks of two accumulator instances (24b/N=8, 16b/N=2).
module tb_product_accumulator;
  logic clk = 1'b0, rst;
  logic v_a, clr_a, ord_a, ir_a, ov_a, ovf_a;
  logic v_b, clr_b, ord_b, ir_b, ov_b, ovf_b;
  logic [15:0] p_a, p_b, acc_b;
  logic [23:0] acc_a;
  int nerr = 0, nchk = 0;
  longint tot[2];
  int cnt[2];
  bit hold[2];
  int nn[2] = '{8, 2};
  int ww[2] = '{24, 16};
  logic v, clr, ord;
  logic [15:0] p;

  product_accumulator #(.ACC_W(24), .N(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(v_a), .in_ready(ir_a), .product(p_a), .clear(clr_a),
    .out_valid(ov_a), .out_ready(ord_a), .acc_out(acc_a), .overflow(ovf_a));
  product_accumulator #(.ACC_W(16), .N(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(v_b), .in_ready(ir_b), .product(p_b), .clear(clr_b),
    .out_valid(ov_b), .out_ready(ord_b), .acc_out(acc_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected register value for a true running total in a w-bit accumulator
  function automatic logic [31:0] exp_acc(input longint t, input int w);
    longint mx = (longint'(1) << w) - 1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    return 32'(t > mx ? mx : t);
`else
    return 32'(t & mx);
`endif
  endfunction

  initial begin
    rst = 1'b1;
    {v_a, clr_a, ord_a, v_b, clr_b, ord_b} = '0;
    p_a = '0; p_b = '0;
    #2;
    chk("rst_ov", ov_a, 0);
    chk("rst_acc", acc_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_ir", ir_a, 1);
    tick();
    rst = 1'b0;
    tick();
    // eight back-to-back 0xFE01 beats
    v_a = 1'b1; p_a = 16'hFE01;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ov_low", ov_a, 0);
      tick();
    end
    chk("b2b_ov", ov_a, 1);
    chk("b2b_acc", acc_a, 32'h07F008);
    chk("b2b_ovf", ovf_a, 0);
    // HOLD stalls, in_valid ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_acc", acc_a, 32'h07F008);
      chk("hold_ir", ir_a, 0);
      chk("hold_ov", ov_a, 1);
    end
    ord_a = 1'b1; v_a = 1'b0;
    tick();
    ord_a = 1'b0;
    chk("hand_ov", ov_a, 0);
    chk("hand_acc", acc_a, 0);
    chk("hand_ir", ir_a, 1);
    // beats 1..8 with random gaps; out_ready in ACCUM must not matter
    for (int k = 1; k <= 8; k++) begin
      repeat ($urandom_range(0, 3)) begin
        v_a = 1'b0; p_a = 16'($urandom); ord_a = 1'($urandom_range(0, 1));
        tick();
      end
      v_a = 1'b1; p_a = 16'(k); ord_a = 1'b0;
      tick();
    end
    v_a = 1'b0;
    chk("gap_ov", ov_a, 1);
    chk("gap_acc", acc_a, 36);
    ord_a = 1'b1;
    tick();
    ord_a = 1'b0;
    // clear discards the partial sum and the concurrent beat
    v_a = 1'b1; p_a = 16'h0100;
    repeat (3) tick();
    clr_a = 1'b1;
    #1;
    chk("clr_ir", ir_a, 0);
    tick();
    clr_a = 1'b0;
    chk("clr_acc", acc_a, 0);
    p_a = 16'd1;
    for (int i = 0; i < 8; i++) begin
      chk("clr_ov_low", ov_a, 0);
      tick();
    end
    v_a = 1'b0;
    chk("clr_ov", ov_a, 1);
    chk("clr_acc8", acc_a, 8);
    ord_a = 1'b1;
    tick();
    ord_a = 1'b0;
    // 16-bit, N=2 overflow
    v_b = 1'b1; p_b = 16'hFE01;
    tick();
    chk("ovfl_ov_low", ov_b, 0);
    tick();
    v_b = 1'b0;
    chk("ovfl_ov", ov_b, 1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    chk("ovfl_acc", acc_b, 32'hFFFF);
`else
    chk("ovfl_acc", acc_b, 32'hFC02);
`endif
    chk("ovfl_flag", ovf_b, 1);
    ord_b = 1'b1;
    tick();
    ord_b = 1'b0;
    chk("ovfl_hand_flag", ovf_b, 0);
    chk("ovfl_hand_acc", acc_b, 0);
    // async reset mid-accumulation (A) and in HOLD (B)
    v_a = 1'b1; p_a = 16'h1234; v_b = 1'b1; p_b = 16'hFE01;
    tick();
    tick();
    v_b = 1'b0;
    tick();
    v_a = 1'b0;
    chk("pre_rst_acc_a", acc_a, 32'h369C);
    chk("pre_rst_ov_b", ov_b, 1);
    chk("pre_rst_ovf_b", ovf_b, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc_a", acc_a, 0);
    chk("arst_ov_a", ov_a, 0);
    chk("arst_ov_b", ov_b, 0);
    chk("arst_acc_b", acc_b, 0);
    chk("arst_ovf_b", ovf_b, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // randomized run against the total-based reference model
    for (int d = 0; d < 2; d++) begin
      tot[d] = 0; cnt[d] = 0; hold[d] = 1'b0;
    end
    for (int c = 0; c < 600; c++) begin
      v = 1'($urandom_range(0, 1));
      p = 16'($urandom);
      clr = $urandom_range(0, 19) == 0;
      ord = $urandom_range(0, 2) == 0;
      v_a = v; p_a = p; clr_a = clr; ord_a = ord;
      v_b = v; p_b = p; clr_b = clr; ord_b = ord;
      #1;
      chk("rnd_ir_a", ir_a, !hold[0] && !clr);
      chk("rnd_ir_b", ir_b, !hold[1] && !clr);
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (clr || (hold[d] && ord)) begin
          tot[d] = 0; cnt[d] = 0; hold[d] = 1'b0;
        end else if (!hold[d] && v) begin
          tot[d] += longint'(p);
          cnt[d]++;
          hold[d] = cnt[d] == nn[d];
        end
      end
      #1;
      chk("rnd_ov_a", ov_a, hold[0]);
      chk("rnd_acc_a", acc_a, exp_acc(tot[0], ww[0]));
      chk("rnd_ovf_a", ovf_a, tot[0] > (longint'(1) << ww[0]) - 1);
      chk("rnd_ov_b", ov_b, hold[1]);
      chk("rnd_acc_b", acc_b, exp_acc(tot[1], ww[1]));
      chk("rnd_ovf_b", ovf_b, tot[1] > (longint'(1) << ww[1]) - 1);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
